// File: rtl/accum_pkg.sv
// accum_pkg: shared controller state, entry-index mapping and saturation bounds
// for the accumulation buffer.
package accum_pkg;
  typedef enum logic {IDLE, CLEAR} state_e;
  localparam int MAX_DATA_WIDTH = 64;
  // Linear tile position folded across banks: consecutive positions stripe over
  // the banks, so the entry is the position with the bank bits shifted out.
  // Callers truncate the result to their entry width.
  function automatic logic [31:0] entry_index(input logic [31:0] row, col, tile_size, bank_log2);
    return (row * tile_size + col) >> bank_log2;
  endfunction
  function automatic logic [MAX_DATA_WIDTH-1:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction
  function automatic logic [MAX_DATA_WIDTH-1:0] sat_min(input int width);
    return ~sat_max(width);
  endfunction
endpackage

// File: rtl/accumulation_bank.sv
// accumulation_bank: one bank of the accumulation buffer -- entry memory, valid
// bits and a two-stage read-modify-write accumulate pipeline with forwarding.
//   clk, reset            clock, synchronous active-high reset (clears valid bits, empties pipeline)
//   clearing, sweep_entry  controller sweep: invalidate sweep_entry, suppress commits
//   wr_en, row, col, wr_data  accumulate request (already gated by buffer_ready)
//   rd_entry, rd_data     combinational read of committed state (invalid reads 0)
//   ovf                   pulse when a saturated sum commits
// Optional macro ACC_BUFFER_SATURATE_EN: clamp sums to the signed range instead of wrapping.
module accumulation_bank import accum_pkg::*; #(
  parameter int BANK_COUNT   = 256,
  parameter int TILE_SIZE    = 256,
  parameter int BUFFER_WIDTH = 256,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clearing,
  input  logic [$clog2(BUFFER_WIDTH)-1:0] sweep_entry,
  input  logic                            wr_en,
  input  logic [$clog2(TILE_SIZE)-1:0]    row,
  input  logic [$clog2(TILE_SIZE)-1:0]    col,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic [$clog2(BUFFER_WIDTH)-1:0] rd_entry,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            ovf
);
  localparam int EW = $clog2(BUFFER_WIDTH);
`ifdef ACC_BUFFER_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(sat_min(DATA_WIDTH));
`endif
  logic [DATA_WIDTH-1:0]   mem_q [BUFFER_WIDTH];
  logic [BUFFER_WIDTH-1:0] valid_q, valid_d;
  logic                    s1_vld_q, s1_vld_d;
  logic [EW-1:0]           s1_entry_q, s1_entry_d;
  logic [DATA_WIDTH-1:0]   s1_add_q, s1_add_d;
  logic                    s2_vld_q, s2_vld_d;
  logic [EW-1:0]           s2_entry_q, s2_entry_d;
  logic [DATA_WIDTH-1:0]   s2_sum_q, s2_sum_d;
  logic                    s2_ovf_q, s2_ovf_d;
  logic [DATA_WIDTH-1:0]   old_val, raw_sum, sum;
  logic                    sum_ovf, commit;
  always_comb begin
    commit = s2_vld_q && !clearing;
    // S2 has not reached memory yet, so a same-entry successor takes its sum.
    old_val = (s2_vld_q && s2_entry_q == s1_entry_q) ? s2_sum_q :
              valid_q[s1_entry_q] ? mem_q[s1_entry_q] : '0;
    raw_sum = old_val + s1_add_q;
`ifdef ACC_BUFFER_SATURATE_EN
    // Signed overflow: operands agree in sign but the sum does not.
    sum_ovf = (old_val[DATA_WIDTH-1] == s1_add_q[DATA_WIDTH-1]) &&
              (raw_sum[DATA_WIDTH-1] != old_val[DATA_WIDTH-1]);
    sum = sum_ovf ? (old_val[DATA_WIDTH-1] ? SAT_MIN : SAT_MAX) : raw_sum;
`else
    sum_ovf = 1'b0;
    sum = raw_sum;
`endif
    s1_vld_d   = wr_en;
    s1_entry_d = EW'(entry_index(32'(row), 32'(col), 32'(TILE_SIZE), 32'($clog2(BANK_COUNT))));
    s1_add_d   = wr_data;
    s2_vld_d   = s1_vld_q;
    s2_entry_d = s1_entry_q;
    s2_sum_d   = sum;
    s2_ovf_d   = sum_ovf;
    valid_d = valid_q;
    if (commit) valid_d[s2_entry_q] = 1'b1;
    if (clearing) valid_d[sweep_entry] = 1'b0;
    rd_data = valid_q[rd_entry] ? mem_q[rd_entry] : '0;
    ovf = commit && s2_ovf_q;
  end
  always_ff @(posedge clk) begin
    if (commit) mem_q[s2_entry_q] <= s2_sum_q;
    s1_entry_q <= s1_entry_d;
    s1_add_q   <= s1_add_d;
    s2_entry_q <= s2_entry_d;
    s2_sum_q   <= s2_sum_d;
    s2_ovf_q   <= s2_ovf_d;
    if (reset) begin
      valid_q  <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end
endmodule

// File: rtl/accumulation_buffer.sv
// accumulation_buffer: banked signed partial-sum buffer with per-bank accumulate
// pipelines, a registered read port and a sweeping clear controller.
//   clk, reset                 clock, synchronous active-high reset
//   buffer_row_write/column_write/data_write/write_enable  per-bank accumulate requests
//   buffer_bank_read, buffer_bank_entry  read select; buffer_data_read one cycle later
//   clear_start                begin invalidating every entry, one entry per cycle
//   buffer_ready               writes accepted (low while clearing)
//   overflow                   sticky saturation flag
// Optional macro ACC_BUFFER_SATURATE_EN: saturating sums; undefined, sums wrap and
// overflow stays 0.
module accumulation_buffer import accum_pkg::*; #(
  parameter int BANK_COUNT   = 256,
  parameter int TILE_SIZE    = 256,
  parameter int BUFFER_WIDTH = 256,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [BANK_COUNT-1:0][$clog2(TILE_SIZE)-1:0] buffer_row_write,
  input  logic [BANK_COUNT-1:0][$clog2(TILE_SIZE)-1:0] buffer_column_write,
  input  logic [BANK_COUNT-1:0][DATA_WIDTH-1:0]        buffer_data_write,
  input  logic [BANK_COUNT-1:0]                        buffer_write_enable,
  input  logic [$clog2(BANK_COUNT)-1:0]                buffer_bank_read,
  input  logic [$clog2(BUFFER_WIDTH)-1:0]              buffer_bank_entry,
  output logic [DATA_WIDTH-1:0]                        buffer_data_read,
  input  logic                                         clear_start,
  output logic                                         buffer_ready,
  output logic                                         overflow
);
  localparam int EW = $clog2(BUFFER_WIDTH);
  state_e                state_q, state_d;
  logic [EW-1:0]         sweep_q, sweep_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  ovf_q, ovf_d;
  logic                  clearing;
  logic [BANK_COUNT-1:0] bank_ovf;
  logic [DATA_WIDTH-1:0] bank_rd [BANK_COUNT];
  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    accumulation_bank #(
      .BANK_COUNT  (BANK_COUNT),
      .TILE_SIZE   (TILE_SIZE),
      .BUFFER_WIDTH(BUFFER_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH)
    ) u_bank (
      .clk        (clk),
      .reset      (reset),
      .clearing   (clearing),
      .sweep_entry(sweep_q),
      .wr_en      (buffer_write_enable[b] && buffer_ready),
      .row        (buffer_row_write[b]),
      .col        (buffer_column_write[b]),
      .wr_data    (buffer_data_write[b]),
      .rd_entry   (buffer_bank_entry),
      .rd_data    (bank_rd[b]),
      .ovf        (bank_ovf[b])
    );
  end
  always_comb begin
    clearing = state_q == CLEAR;
    buffer_ready = !clearing && !clear_start;
    // clear_start also restarts a sweep already in progress.
    state_d = clear_start ? CLEAR :
              (clearing && sweep_q == EW'(BUFFER_WIDTH - 1)) ? IDLE : state_q;
    sweep_d = (clear_start || !clearing) ? '0 : sweep_q + 1'b1;
    rd_d = clearing ? '0 : bank_rd[buffer_bank_read];
    ovf_d = clear_start ? 1'b0 : ovf_q | (|bank_ovf);
    buffer_data_read = rd_q;
    overflow = ovf_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sweep_q <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_accumulation_buffer.sv
// tb_accumulation_buffer: randomized and directed checks of accumulation_buffer against a value-level model.
module tb_accumulation_buffer;
  localparam int NB = 4, TS = 8, BW = 16, DW = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [NB-1:0][2:0]    row_w, col_w;
  logic [NB-1:0][DW-1:0] data_w;
  logic [NB-1:0]         we;
  logic [1:0]            rd_bank;
  logic [3:0]            rd_entry;
  logic [DW-1:0]         rd_data;
  logic                  clear_start, ready, ovf;
  int m [NB][BW];
  bit m_ovf;
  int m_busy;
  int n_cmp, n_bad;
  accumulation_buffer #(.BANK_COUNT(NB), .TILE_SIZE(TS), .BUFFER_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .buffer_row_write(row_w), .buffer_column_write(col_w),
    .buffer_data_write(data_w), .buffer_write_enable(we),
    .buffer_bank_read(rd_bank), .buffer_bank_entry(rd_entry),
    .buffer_data_read(rd_data), .clear_start(clear_start),
    .buffer_ready(ready), .overflow(ovf)
  );
  function automatic int entry_of(int r, int c);
    return ((r * TS + c) / NB) % BW;
  endfunction
  task automatic zero_model();
    for (int b = 0; b < NB; b++) for (int e = 0; e < BW; e++) m[b][e] = 0;
  endtask
  task automatic step();
    bit acc;
    acc = !reset && !clear_start && m_busy == 0;
    @(posedge clk); #1;
    if (reset) begin
      zero_model(); m_ovf = 0; m_busy = 0;
    end else if (clear_start) begin
      zero_model(); m_ovf = 0; m_busy = BW;
    end else begin
      if (m_busy > 0) m_busy--;
      if (acc) for (int b = 0; b < NB; b++) if (we[b]) begin
        int e, s;
        e = entry_of(int'(row_w[b]), int'(col_w[b]));
        s = m[b][e] + int'($signed(data_w[b]));
`ifdef ACC_BUFFER_SATURATE_EN
        if (s > 32767) begin s = 32767; m_ovf = 1; end
        else if (s < -32768) begin s = -32768; m_ovf = 1; end
`else
        if (s > 32767) s -= 65536;
        else if (s < -32768) s += 65536;
`endif
        m[b][e] = s;
      end
    end
  endtask
  task automatic set_wr(int b, int r, int c, int d);
    row_w[b] = 3'(r); col_w[b] = 3'(c); data_w[b] = 16'(d); we[b] = 1'b1;
  endtask
  task automatic idle(int n);
    we = '0;
    repeat (n) step();
  endtask
  task automatic read_entry(input int b, input int e, output logic [DW-1:0] v);
    we = '0; rd_bank = 2'(b); rd_entry = 4'(e);
    step();
    v = rd_data;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL reset_read: got %0d want 0", rd_data); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask
  task automatic test_single();
    logic [DW-1:0] v;
    set_wr(1, 2, 5, 7);
    step();
    idle(2);
    read_entry(1, 5, v);
    n_cmp++; if (v !== 16'd7) begin n_bad++; $display("FAIL single: got %0d want 7", v); end
  endtask
  task automatic test_back_to_back();
    logic [DW-1:0] v;
    set_wr(0, 0, 0, 3);
    repeat (4) begin
      #1;
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", ready); end
      step();
    end
    idle(3);
    read_entry(0, 0, v);
    n_cmp++; if (v !== 16'd12) begin n_bad++; $display("FAIL back_to_back: got %0d want 12", v); end
  endtask
  task automatic test_parallel();
    logic [DW-1:0] v;
    for (int b = 0; b < NB; b++) set_wr(b, 1, 4, b + 1);
    step();
    idle(3);
    for (int b = 0; b < NB; b++) begin
      read_entry(b, 3, v);
      n_cmp++; if (v !== 16'(b + 1)) begin n_bad++; $display("FAIL parallel bank%0d: got %0d want %0d", b, v, b + 1); end
    end
  endtask
  task automatic test_overflow();
    logic [DW-1:0] v, exp_v;
    logic exp_o;
`ifdef ACC_BUFFER_SATURATE_EN
    exp_v = 16'h7fff; exp_o = 1'b1;
`else
    exp_v = 16'h8000; exp_o = 1'b0;
`endif
    set_wr(2, 0, 0, 32767); step();
    set_wr(2, 0, 0, 1); step();
    idle(3);
    read_entry(2, 0, v);
    n_cmp++; if (v !== exp_v) begin n_bad++; $display("FAIL overflow_value: got %h want %h", v, exp_v); end
    n_cmp++; if (ovf !== exp_o) begin n_bad++; $display("FAIL overflow_flag: got %b want %b", ovf, exp_o); end
  endtask
  task automatic test_random();
    logic [DW-1:0] v;
    for (int i = 0; i < 300; i++) begin
      for (int b = 0; b < NB; b++) begin
        int d;
        d = int'($urandom_range(0, 200)) - 100;
        row_w[b] = 3'($urandom_range(0, 7));
        col_w[b] = 3'($urandom_range(0, 7));
        data_w[b] = 16'(d);
      end
      we = 4'($urandom);
      step();
    end
    idle(3);
    for (int b = 0; b < NB; b++) for (int e = 0; e < BW; e++) begin
      int x;
      x = m[b][e];
      read_entry(b, e, v);
      n_cmp++; if (v !== 16'(x)) begin n_bad++; $display("FAIL random b%0d e%0d: got %0d want %0d", b, e, $signed(v), x); end
    end
    n_cmp++; if (ovf !== m_ovf) begin n_bad++; $display("FAIL random_ovf: got %b want %b", ovf, m_ovf); end
  endtask
  task automatic test_clear();
    logic [DW-1:0] v;
    int low;
    low = 0;
    we = '0; clear_start = 1'b1;
    #1; if (!ready) low++;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) set_wr(3, 0, 0, 5); else we = '0;
      rd_bank = 2'd1; rd_entry = 4'd5;
      #1; if (ready) break;
      low++;
      step();
      n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL clear_read cycle%0d: got %0d want 0", i, rd_data); end
    end
    n_cmp++; if (low !== 17) begin n_bad++; $display("FAIL clear_busy_cycles: got %0d want 17", low); end
    idle(3);
    for (int b = 0; b < NB; b++) for (int e = 0; e < BW; e++) begin
      read_entry(b, e, v);
      n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL cleared b%0d e%0d: got %0d want 0", b, e, v); end
    end
  endtask
  task automatic test_restart();
    logic [DW-1:0] v;
    int low;
    set_wr(2, 7, 7, 11); step(); idle(3);
    read_entry(2, 15, v);
    n_cmp++; if (v !== 16'd11) begin n_bad++; $display("FAIL restart_prefill: got %0d want 11", v); end
    low = 0;
    clear_start = 1'b1;
    #1; if (!ready) low++;
    step();
    for (int i = 0; i < 40; i++) begin
      clear_start = (i == 5);
      #1; if (ready) break;
      low++;
      step();
    end
    clear_start = 1'b0;
    n_cmp++; if (low !== 23) begin n_bad++; $display("FAIL restart_busy_cycles: got %0d want 23", low); end
    idle(2);
    read_entry(2, 15, v);
    n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL restart_cleared: got %0d want 0", v); end
  endtask
  task automatic test_reset_mid_sweep();
    logic [DW-1:0] v;
    set_wr(1, 5, 0, 21); step(); idle(3);
    clear_start = 1'b1; step(); clear_start = 1'b0;
    repeat (6) step();
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_sweep_ready: got %b want 0", ready); end
    reset = 1'b1; step(); reset = 1'b0;
    n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL post_reset_read: got %0d want 0", rd_data); end
    set_wr(0, 3, 7, 9);
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", ready); end
    step();
    idle(3);
    read_entry(0, 7, v);
    n_cmp++; if (v !== 16'd9) begin n_bad++; $display("FAIL post_reset_write: got %0d want 9", v); end
    read_entry(1, 10, v);
    n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL reset_invalidates: got %0d want 0", v); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL post_reset_ovf: got %b want 0", ovf); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    n_cmp = 0; n_bad = 0; m_ovf = 0; m_busy = 0;
    zero_model();
    row_w = '0; col_w = '0; data_w = '0; we = '0;
    rd_bank = '0; rd_entry = '0; clear_start = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_parallel();
    test_overflow();
    test_random();
    test_clear();
    test_restart();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/accumulation_buffer.md
ACCUMULATION_BUFFER -- requirements
Module: accumulation_buffer

Interface
REQ-001 Parameter BANK_COUNT, default 256: number of independent banks, one write port each.
REQ-002 Parameter TILE_SIZE, default 256: row/column coordinate range.
REQ-003 Parameter BUFFER_WIDTH, default 256: entries per bank.
REQ-004 Parameter DATA_WIDTH, default 16: signed partial-sum width.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 buffer_row_write[BANK_COUNT]  input  clog2(TILE_SIZE)  per-bank write row.
REQ-009 buffer_column_write[BANK_COUNT]  input  clog2(TILE_SIZE)  per-bank write column.
REQ-010 buffer_data_write[BANK_COUNT]  input  DATA_WIDTH  signed addend.
REQ-011 buffer_write_enable[BANK_COUNT]  input  1  per-bank accumulate request.
REQ-012 buffer_bank_read  input  clog2(BANK_COUNT)  read bank select.
REQ-013 buffer_bank_entry  input  clog2(BUFFER_WIDTH)  read entry select.
REQ-014 buffer_data_read  output  DATA_WIDTH  registered read data.
REQ-015 clear_start  input  1  pulse: begin invalidating all entries.
REQ-016 buffer_ready  output  1  high when writes are accepted.
REQ-017 overflow  output  1  sticky saturation flag (ACC_BUFFER_SATURATE_EN only).

Function
REQ-018 Entry index SHALL be (row*TILE_SIZE + column) >> clog2(BANK_COUNT), truncated to clog2(BUFFER_WIDTH) bits; bank is the port index.
REQ-019 Each entry SHALL hold a valid bit and a DATA_WIDTH value; invalid entries read as 0 and accumulate from 0.
REQ-020 Accumulate SHALL be a 2-stage pipeline per bank: S1 registers entry/addend and reads stored value; S2 writes sum and sets valid.
REQ-021 Back-to-back writes to the same bank entry SHALL forward the S2 sum into S1, so N consecutive writes of value v yield N*v without loss.
REQ-022 Writes to different banks in the same cycle SHALL proceed independently and in parallel.
REQ-023 Read latency SHALL be 1 cycle; read returns committed memory state only (no bypass from S1/S2); a same-cycle S2 commit to the read entry is not visible until next cycle.
REQ-024 States: IDLE, CLEAR; IDLE->CLEAR on clear_start; CLEAR sweeps entry 0..BUFFER_WIDTH-1, one per cycle, all banks in parallel; CLEAR->IDLE after entry BUFFER_WIDTH-1.
REQ-025 buffer_ready SHALL be 0 in CLEAR and for the cycle clear_start is sampled; write_enable while not ready is dropped.
REQ-026 In-flight S1/S2 operations at clear_start SHALL complete before the sweep reaches their entry is irrelevant: the sweep invalidates entry 0 first and S2 commits are suppressed during CLEAR.
REQ-027 Reads during CLEAR SHALL return 0.
REQ-028 clear_start while already in CLEAR SHALL restart the sweep at entry 0.

Reset
REQ-029 Reset SHALL clear all valid bits (no sweep), state=IDLE, buffer_ready=1, buffer_data_read=0, overflow=0, pipeline stages empty.
REQ-030 Reset asserted mid-sweep or mid-accumulate SHALL abort it; first post-reset cycle accepts writes.

Configuration
REQ-031 Macro ACC_BUFFER_SATURATE_EN defined: sums clamp to signed DATA_WIDTH min/max and set sticky overflow (cleared by reset or clear_start).
REQ-032 Macro undefined: sums wrap modulo 2^DATA_WIDTH; overflow port tied 0.

Structure
REQ-033 Shared package accum_pkg SHALL hold the state enum, the entry-index function and saturation constants.
REQ-034 One sub-module accumulation_bank (one bank's memory, valid bits, RMW pipeline, forwarding) SHALL be instantiated BANK_COUNT times via generate.

Verification (BANK_COUNT=4, TILE_SIZE=8, BUFFER_WIDTH=16, DATA_WIDTH=16)
REQ-035 Bank 1 write row=2,col=5,data=7 once; read bank 1 entry 5 three cycles later -> 7.
REQ-036 Bank 0 writes (0,0) data=3 on 4 consecutive cycles -> entry 0 reads 12.
REQ-037 All 4 banks write (1,4) data=1,2,3,4 same cycle -> entry 3 of banks 0..3 read 1,2,3,4.
REQ-038 Saturate build: write 32767 then 1 to same entry -> reads 32767, overflow=1; non-saturate build -> -32768, overflow=0.
REQ-039 Fill entries, pulse clear_start, write during sweep -> buffer_ready=0 for 17 cycles, all reads 0 after, dropped write absent.
REQ-040 Reset asserted at sweep entry 6 -> next cycle buffer_ready=1, all entries read 0.
